datapath_seq: RTL and testbench

Parametrised, self-sequencing successor to the lab datapath. It combines the following into one block behind a single valid/ready operation handshake:
- the register file;
- A/B/C operand registers;
- shifter and ALU;
- status register;
- the 4-source writeback mux.

An internal FSM steps each accepted operation through operand fetch, execute and writeback, then pulses `done`. The controller upstream issues one decoded operation at a time.

---
 rtl/datapath_seq_pkg.sv | 55 +++++
 rtl/datapath_seq_regfile.sv | 52 +++++
 rtl/datapath_seq.sv | 270 +++++++++++++++++++++++++++
 tb/tb_datapath_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_seq_pkg.sv
// -----------------------------------------------------------------------------
// datapath_seq_pkg
//   Shared types and constants for the self-sequencing datapath:
//   - state_t    : operation sequencer states
//   - alu_op_t   : ALU operation codes
//   - shift_t    : B-operand shifter codes
//   - VSEL_*     : one-hot writeback source selects
//   - ctrl_t     : decoded control fields captured with each operation
//   - vsel_onehot: true when a writeback select names exactly one source
// -----------------------------------------------------------------------------
package datapath_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADA = 3'd1,
    ST_LOADB = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WB    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_t;

  localparam logic [3:0] VSEL_MDATA = 4'b1000;
  localparam logic [3:0] VSEL_IMM8  = 4'b0100;
  localparam logic [3:0] VSEL_PC    = 4'b0010;
  localparam logic [3:0] VSEL_C     = 4'b0001;

  // Width-independent control fields of one operation.
  typedef struct packed {
    logic       asel;
    logic       bsel;
    shift_t     shift;
    alu_op_t    aluop;
    logic [3:0] vsel;
    logic       write;
    logic       loads;
  } ctrl_t;

  function automatic logic vsel_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/datapath_seq_regfile.sv
// -----------------------------------------------------------------------------
// datapath_seq_regfile
//   NREG x W general register file, cleared by asynchronous reset.
//   One synchronous write port, two combinational read ports.
// Ports:
//   clk, reset          clock / async active-high reset
//   we, waddr, wdata    write port (written on the rising edge when we=1)
//   raddr_a -> rdata_a  read port A (combinational)
//   raddr_b -> rdata_b  read port B (combinational)
// -----------------------------------------------------------------------------
module datapath_seq_regfile
  import datapath_seq_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [RW-1:0] raddr_a,
  output logic [W-1:0]  rdata_a,
  input  logic [RW-1:0] raddr_b,
  output logic [W-1:0]  rdata_b
);

  logic [W-1:0] rf_q [NREG];

  // Each register is its own flop bank with a decoded write enable, so the
  // whole file can be cleared by the asynchronous reset.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic [W-1:0] q_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q_reg <= '0;
        end else if (we && (waddr == RW'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign rf_q[gi] = q_reg;
    end
  endgenerate

  assign rdata_a = rf_q[raddr_a];
  assign rdata_b = rf_q[raddr_b];

endmodule

// File: rtl/datapath_seq.sv
// -----------------------------------------------------------------------------
// datapath_seq
//   Self-sequencing datapath: register file, A/B/C operand registers, B-side
//   shifter, ALU, Z/V/N status flags and a 4-source writeback mux behind one
//   valid/ready operation handshake. Each accepted operation is captured in an
//   op register and stepped through LOADA -> LOADB -> EXEC -> WB (or straight
//   to WB when the writeback source is not C), then `done` pulses for a cycle.
// Ports:
//   clk, reset               clock / async active-high reset
//   op_valid, op_ready       operation handshake (accept when both high)
//   rn, rm, rd               A-source, B-source, destination registers
//   asel, bsel, shift, aluop operand selects, shifter and ALU op
//   vsel                     one-hot writeback source (mdata/imm8/pc/C)
//   write, loads             register write enable / flag update enable
//   mdata, sximm8, sximm5    external data and immediates
//   pc                       program counter (zero-extended on writeback)
//   done                     one-cycle completion pulse (WB state)
//   c, zout, vout, nout      C register and status flags
// -----------------------------------------------------------------------------
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int PCW  = 8,
  localparam int RW  = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [RW-1:0]  rn,
  input  logic [RW-1:0]  rm,
  input  logic [RW-1:0]  rd,
  input  logic           asel,
  input  logic           bsel,
  input  logic [1:0]     shift,
  input  logic [1:0]     aluop,
  input  logic [3:0]     vsel,
  input  logic           write,
  input  logic           loads,
  input  logic [W-1:0]   mdata,
  input  logic [W-1:0]   sximm8,
  input  logic [W-1:0]   sximm5,
  input  logic [PCW-1:0] pc,
  output logic           done,
  output logic [W-1:0]   c,
  output logic           zout,
  output logic           vout,
  output logic           nout
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t         state_reg, state_next;

  ctrl_t          ctrl_reg;
  logic [RW-1:0]  rn_reg, rm_reg, rd_reg;
  logic [W-1:0]   mdata_reg, imm8_reg, imm5_reg;
  logic [PCW-1:0] pc_reg;

  logic [W-1:0]   a_reg, b_reg, c_reg;
  logic           z_reg, v_reg, n_reg;

  logic           accept;
  logic           ld_a, ld_b, ld_c;

  logic [W-1:0]   rdata_a, rdata_b;
  logic [W-1:0]   b_shifted;
  logic [W-1:0]   ain, bin;
  logic [W-1:0]   alu_out;
  logic           alu_v;
  logic [W-1:0]   wb_data;
  logic           rf_we;

  assign accept = op_valid && op_ready;

  // ---------------------------------------------------------------------------
  // Sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: next state
  // Only a C writeback needs the ALU; every other select (including a
  // malformed, non-one-hot one) takes the short path straight to WB.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (accept) state_next = (vsel == VSEL_C) ? ST_LOADA : ST_WB;
      ST_LOADA: state_next = ST_LOADB;
      ST_LOADB: state_next = ST_EXEC;
      ST_EXEC:  state_next = ST_WB;
      ST_WB:    state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer: outputs / datapath strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    op_ready = 1'b0;
    done     = 1'b0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_c     = 1'b0;
    unique case (state_reg)
      ST_IDLE:  op_ready = 1'b1;
      ST_LOADA: ld_a     = 1'b1;
      ST_LOADB: ld_b     = 1'b1;
      ST_EXEC:  ld_c     = 1'b1;
      ST_WB:    done     = 1'b1;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Op register: every field and operand is frozen at acceptance so upstream
  // may move on immediately.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_reg  <= '0;
      rn_reg    <= '0;
      rm_reg    <= '0;
      rd_reg    <= '0;
      mdata_reg <= '0;
      imm8_reg  <= '0;
      imm5_reg  <= '0;
      pc_reg    <= '0;
    end else if (accept) begin
      ctrl_reg.asel  <= asel;
      ctrl_reg.bsel  <= bsel;
      ctrl_reg.shift <= shift_t'(shift);
      ctrl_reg.aluop <= alu_op_t'(aluop);
      ctrl_reg.vsel  <= vsel;
      ctrl_reg.write <= write;
      ctrl_reg.loads <= loads;
      rn_reg         <= rn;
      rm_reg         <= rm;
      rd_reg         <= rd;
      mdata_reg      <= mdata;
      imm8_reg       <= sximm8;
      imm5_reg       <= sximm5;
      pc_reg         <= pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  datapath_seq_regfile #(
    .W    (W),
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rd_reg),
    .wdata   (wb_data),
    .raddr_a (rn_reg),
    .rdata_a (rdata_a),
    .raddr_b (rm_reg),
    .rdata_b (rdata_b)
  );

  // ---------------------------------------------------------------------------
  // A/B operand registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (ld_a) a_reg <= rdata_a;
      if (ld_b) b_reg <= rdata_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Shifter (acts on B only)
  // ---------------------------------------------------------------------------
  always_comb begin
    b_shifted = b_reg;
    unique case (ctrl_reg.shift)
      SH_NONE: b_shifted = b_reg;
      SH_LSL1: b_shifted = {b_reg[W-2:0], 1'b0};
      SH_LSR1: b_shifted = {1'b0, b_reg[W-1:1]};
      SH_ASR1: b_shifted = {b_reg[W-1], b_reg[W-1:1]};
      default: b_shifted = b_reg;
    endcase
  end

  assign ain = ctrl_reg.asel ? '0 : a_reg;
  assign bin = ctrl_reg.bsel ? imm5_reg : b_shifted;

  // ---------------------------------------------------------------------------
  // ALU. Overflow: ADD overflows when both operands share a sign the result
  // lacks; SUB overflows when the operand signs differ and the result sign
  // differs from A. Logical ops never overflow.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_out = '0;
    alu_v   = 1'b0;
    unique case (ctrl_reg.aluop)
      ALU_ADD: begin
        alu_out = ain + bin;
        alu_v   = (ain[W-1] == bin[W-1]) && (alu_out[W-1] != ain[W-1]);
      end
      ALU_SUB: begin
        alu_out = ain - bin;
        alu_v   = (ain[W-1] != bin[W-1]) && (alu_out[W-1] != ain[W-1]);
      end
      ALU_AND: alu_out = ain & bin;
      ALU_MVN: alu_out = ~bin;
      default: alu_out = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // C register and status flags: only EXEC changes them, so they hold across
  // short-path operations and idle time.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_reg <= '0;
      z_reg <= 1'b0;
      v_reg <= 1'b0;
      n_reg <= 1'b0;
    end else if (ld_c) begin
      c_reg <= alu_out;
      if (ctrl_reg.loads) begin
        z_reg <= (alu_out == '0);
        v_reg <= alu_v;
        n_reg <= alu_out[W-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback mux. A non-one-hot select produces no write at all.
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_data = '0;
    case (ctrl_reg.vsel)
      VSEL_MDATA: wb_data = mdata_reg;
      VSEL_IMM8:  wb_data = imm8_reg;
      VSEL_PC:    wb_data = W'(pc_reg);
      VSEL_C:     wb_data = c_reg;
      default:    wb_data = '0;
    endcase
  end

  assign rf_we = done && ctrl_reg.write && vsel_onehot(ctrl_reg.vsel);

  assign c    = c_reg;
  assign zout = z_reg;
  assign vout = v_reg;
  assign nout = n_reg;

endmodule

// File: tb/tb_datapath_seq.sv
module tb_datapath_seq;

  localparam int W    = 16;
  localparam int NREG = 8;
  localparam int PCW  = 8;
  localparam int RW   = 3;
  localparam int NV   = 28;

  localparam logic [3:0] VC = 4'b0001;
  localparam logic [3:0] VP = 4'b0010;
  localparam logic [3:0] VI = 4'b0100;
  localparam logic [3:0] VM = 4'b1000;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           op_valid = 1'b0;
  logic           op_ready;
  logic [RW-1:0]  rn = '0, rm = '0, rd = '0;
  logic           asel = 1'b0, bsel = 1'b0;
  logic [1:0]     shift = '0, aluop = '0;
  logic [3:0]     vsel = '0;
  logic           write = 1'b0, loads = 1'b0;
  logic [W-1:0]   mdata = '0, sximm8 = '0, sximm5 = '0;
  logic [PCW-1:0] pc = '0;
  logic           done;
  logic [W-1:0]   c;
  logic           zout, vout, nout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  datapath_seq #(.W(W), .NREG(NREG), .PCW(PCW)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .rn(rn), .rm(rm), .rd(rd), .asel(asel), .bsel(bsel), .shift(shift),
    .aluop(aluop), .vsel(vsel), .write(write), .loads(loads),
    .mdata(mdata), .sximm8(sximm8), .sximm5(sximm5), .pc(pc),
    .done(done), .c(c), .zout(zout), .vout(vout), .nout(nout)
  );

  typedef struct packed {
    logic [3:0]  vsel;
    logic [2:0]  rn, rm, rd;
    logic        asel, bsel;
    logic [1:0]  shift, aluop;
    logic        write, loads;
    logic [15:0] mdata, imm8, imm5;
    logic [7:0]  pc;
    logic [3:0]  lat;
    logic [15:0] c;
    logic [2:0]  znv;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(input logic [3:0] vs, input logic [2:0] a, b, d,
                              input logic as_, bs, input logic [1:0] sh_, al,
                              input logic wr, ld, input logic [15:0] md, i8, i5,
                              input logic [7:0] p, input logic [15:0] ec,
                              input logic [2:0] znv);
    vec_t t;
    t.vsel = vs; t.rn = a; t.rm = b; t.rd = d; t.asel = as_; t.bsel = bs;
    t.shift = sh_; t.aluop = al; t.write = wr; t.loads = ld;
    t.mdata = md; t.imm8 = i8; t.imm5 = i5; t.pc = p;
    t.lat = (vs == VC) ? 4'd4 : 4'd1;
    t.c = ec; t.znv = znv;
    return t;
  endfunction

  // Short-path write of an 8-bit-immediate value into a register.
  function automatic vec_t sh8(input logic [2:0] d, input logic [15:0] val,
                               input logic [15:0] ec, input logic [2:0] znv);
    return mk(VI, 3'd0, 3'd0, d, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0,
              16'hDEAD, val, 16'hDEAD, 8'h00, ec, znv);
  endfunction

  // Readback: C = 0 + R[r], no flag update, no register write.
  function automatic vec_t rb(input logic [2:0] r, input logic [15:0] ec,
                              input logic [2:0] znv);
    return mk(VC, 3'd0, r, 3'd0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0,
              16'hDEAD, 16'hDEAD, 16'hDEAD, 8'h00, ec, znv);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    vsel = t.vsel; rn = t.rn; rm = t.rm; rd = t.rd; asel = t.asel; bsel = t.bsel;
    shift = t.shift; aluop = t.aluop; write = t.write; loads = t.loads;
    mdata = t.mdata; sximm8 = t.imm8; sximm5 = t.imm5; pc = t.pc;
  endtask

  task automatic scramble();
    vsel = 4'b1111; rn = 3'd7; rm = 3'd7; rd = 3'd7; asel = 1'b0; bsel = 1'b1;
    shift = 2'b11; aluop = 2'b11; write = 1'b1; loads = 1'b1;
    mdata = 16'h9999; sximm8 = 16'h9999; sximm5 = 16'h9999; pc = 8'h99;
  endtask

  // Called at a negedge; returns at the negedge after the op is back in IDLE.
  task automatic run_op(input vec_t t, input string nm, output int lat);
    int   wn;
    logic busy_ready;
    wn = 0;
    while (!op_ready && wn < 20) begin
      @(negedge clk);
      wn++;
    end
    chk({nm, " ready_at_issue"}, op_ready, 1);
    drive(t);
    op_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    busy_ready = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    scramble();
    while (!done && lat < 20) begin
      busy_ready |= op_ready;
      @(negedge clk);
      lat++;
    end
    busy_ready |= op_ready;
    chk({nm, " ready_low_while_busy"}, busy_ready, 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    string nm;

    //            vsel rn    rm    rd    as    bs    sh     alu    wr    ld    mdata     imm8      imm5      pc     exp c     znv
    vt[0]  = sh8(3'd1, 16'h0007, 16'h0000, 3'b000);
    vt[1]  = rb (3'd1, 16'h0007, 3'b000);
    vt[2]  = sh8(3'd2, 16'h0002, 16'h0007, 3'b000);
    vt[3]  = mk(VC, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 16'hDEAD, 16'hDEAD, 16'hDEAD, 8'h00, 16'h000B, 3'b000);
    vt[4]  = rb (3'd3, 16'h000B, 3'b000);
    vt[5]  = sh8(3'd0, 16'h8000, 16'h000B, 3'b000);
    vt[6]  = sh8(3'd1, 16'h0001, 16'h000B, 3'b000);
    vt[7]  = mk(VC, 3'd0, 3'd1, 3'd7, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 16'hDEAD, 16'hDEAD, 16'hDEAD, 8'h00, 16'h7FFF, 3'b010);
    vt[8]  = sh8(3'd1, 16'h8000, 16'h7FFF, 3'b010);
    vt[9]  = mk(VC, 3'd0, 3'd1, 3'd7, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 16'hDEAD, 16'hDEAD, 16'hDEAD, 8'h00, 16'h0000, 3'b100);
    vt[10] = mk(VC, 3'd0, 3'd0, 3'd7, 1'b0, 1'b1, 2'b00, 2'b11, 1'b0, 1'b1, 16'hDEAD, 16'hDEAD, 16'hFFF0, 8'h00, 16'h000F, 3'b000);
    vt[11] = mk(VP, 3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 16'hDEAD, 16'hDEAD, 16'hDEAD, 8'hA5, 16'h000F, 3'b000);
    vt[12] = rb (3'd4, 16'h00A5, 3'b000);
    vt[13] = mk(4'b0011, 3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 16'h1234, 16'h5555, 16'h6666, 8'h77, 16'h00A5, 3'b000);
    vt[14] = rb (3'd4, 16'h00A5, 3'b000);
    vt[15] = mk(VM, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 16'hBEEF, 16'h1111, 16'h2222, 8'h33, 16'h00A5, 3'b000);
    vt[16] = rb (3'd5, 16'hBEEF, 3'b000);
    vt[17] = sh8(3'd6, 16'h8004, 16'hBEEF, 3'b000);
    vt[18] = mk(VC, 3'd0, 3'd6, 3'd7, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 16'hDEAD, 16'hDEAD, 16'hDEAD, 8'h00, 16'hC002, 3'b001);
    vt[19] = mk(VC, 3'd0, 3'd6, 3'd7, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 16'hDEAD, 16'hDEAD, 16'hDEAD, 8'h00, 16'h4002, 3'b000);
    vt[20] = mk(VC, 3'd5, 3'd6, 3'd7, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 16'hDEAD, 16'hDEAD, 16'hDEAD, 8'h00, 16'h8004, 3'b001);
    vt[21] = mk(VC, 3'd5, 3'd6, 3'd7, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'hDEAD, 16'hDEAD, 16'hDEAD, 8'h00, 16'h3EF3, 3'b001);
    vt[22] = mk(VI, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'hDEAD, 16'h1111, 16'hDEAD, 8'h00, 16'h3EF3, 3'b001);
    vt[23] = rb (3'd5, 16'hBEEF, 3'b001);
    vt[24] = mk(VC, 3'd4, 3'd4, 3'd4, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 16'hDEAD, 16'hDEAD, 16'hDEAD, 8'h00, 16'h014A, 3'b001);
    vt[25] = rb (3'd4, 16'h014A, 3'b001);
    vt[26] = sh8(3'd2, 16'h7FFF, 16'h014A, 3'b001);
    vt[27] = mk(VC, 3'd2, 3'd2, 3'd7, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 16'hDEAD, 16'hDEAD, 16'hDEAD, 8'h00, 16'hFFFE, 3'b011);

    // ---- Reset state ----
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset op_ready", op_ready, 1);
    chk("reset done", done, 0);
    chk("reset c", c, 16'h0000);
    chk("reset flags", {zout, vout, nout}, 3'b000);

    // ---- Table-driven operations ----
    for (int i = 0; i < NV; i++) begin
      nm = $sformatf("vec%0d", i);
      run_op(vt[i], nm, lat);
      chk({nm, " latency"}, lat, vt[i].lat);
      chk({nm, " c"}, c, vt[i].c);
      chk({nm, " znv"}, {zout, vout, nout}, vt[i].znv);
      $display("op %0d: vsel=%b rn=%0d rm=%0d rd=%0d alu=%b sh=%b -> c=%h znv=%b lat=%0d",
               i, vt[i].vsel, vt[i].rn, vt[i].rm, vt[i].rd, vt[i].aluop, vt[i].shift,
               c, {zout, vout, nout}, lat);
    end

    // ---- Handshake: op_valid held, short path, fields change every cycle ----
    for (int k = 0; k <= 6; k++) begin
      chk($sformatf("hs_short k%0d ready", k), op_ready, (k % 2 == 0));
      chk($sformatf("hs_short k%0d done", k), done, (k % 2 == 1));
      if (k < 5) begin
        drive(sh8(3'd7, 16'h0100 + 16'(k), 16'h0, 3'b000));
        op_valid = 1'b1;
      end else begin
        op_valid = 1'b0;
        sximm8 = 16'hDEAD;
      end
      @(negedge clk);
    end
    run_op(rb(3'd7, 16'h0104, 3'b011), "hs_short rb", lat);
    chk("hs_short R7", c, 16'h0104);
    $display("handshake short: R7=%h", c);

    // ---- Handshake: op_valid held, full path; rm only valid on accept cycles ----
    for (int k = 0; k <= 11; k++) begin
      chk($sformatf("hs_full k%0d ready", k), op_ready, (k == 0 || k == 5 || k >= 10));
      chk($sformatf("hs_full k%0d done", k), done, (k == 4 || k == 9));
      if (k == 5) chk("hs_full first c", c, 16'h0104);
      drive(rb(((k == 0) || (k == 5)) ? 3'd7 : 3'd0, 16'h0, 3'b000));
      op_valid = (k < 8);
      @(negedge clk);
    end
    chk("hs_full second c", c, 16'h0104);
    chk("hs_full flags held", {zout, vout, nout}, 3'b011);
    $display("handshake full: c=%h", c);

    // ---- Asynchronous reset while in EXEC ----
    drive(mk(VC, 3'd0, 3'd7, 3'd6, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1,
             16'h0, 16'h0, 16'h0, 8'h00, 16'h0, 3'b000));
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    scramble();
    @(negedge clk);
    @(negedge clk);
    chk("rst_exec pre ready", op_ready, 0);
    chk("rst_exec pre done", done, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_exec async c", c, 16'h0000);
    chk("rst_exec async flags", {zout, vout, nout}, 3'b000);
    chk("rst_exec async done", done, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_exec idle k%0d done", k), done, 0);
      chk($sformatf("rst_exec idle k%0d ready", k), op_ready, 1);
      @(negedge clk);
    end
    run_op(rb(3'd6, 16'h0, 3'b000), "rst_exec rb6", lat);
    chk("rst_exec R6", c, 16'h0000);
    run_op(rb(3'd7, 16'h0, 3'b000), "rst_exec rb7", lat);
    chk("rst_exec R7", c, 16'h0000);
    run_op(rb(3'd5, 16'h0, 3'b000), "rst_exec rb5", lat);
    chk("rst_exec R5", c, 16'h0000);
    chk("rst_exec flags", {zout, vout, nout}, 3'b000);
    $display("reset in EXEC: R5/R6/R7 readback done, c=%h", c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
